// File: rtl/scan_mux_reg.sv
// scan_mux_reg: registered N:1 channel selector with a latched select,
// a registered output with valid flag, and an auto-scan (round-robin) mode.
// Optional feature macro: CH_MASK_EN adds a per-channel exclusion mask
// (ch_mask) that scan mode skips over and manual mode refuses to sample.
module scan_mux_reg #(
    parameter int WIDTH = 8,
    parameter int N = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               load,
    input  logic               mode,
    input  logic               en,
`ifdef CH_MASK_EN
    input  logic [N-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] chan [N];
    logic [SEL_W-1:0] eff_raw;
    logic [SEL_W-1:0] eff_sel;
    logic [SEL_W-1:0] samp_sel;
    logic [SEL_W-1:0] sel_nxt;
    logic             take;
    logic             wrap_nxt;

    // Unpack the flat channel bus so the sample can be a plain array index
    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = data_in[k*WIDTH +: WIDTH];
    end

    // Effective select: a same-cycle load overrides the latched select;
    // out-of-range indices (only possible for non-power-of-2 N) fold to 0
    always_comb begin
        eff_raw = load ? sel_in : cur_sel;
        eff_sel = ({1'b0, eff_raw} >= N_EXT) ? '0 : eff_raw;
    end

    // Next state follows en/mode directly from every state, so a mode change
    // is acted on in the same cycle it is sampled
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, MANUAL, SCAN: begin
                if (en) next_state = mode ? SCAN : MANUAL;
                else    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef CH_MASK_EN
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] after_idx;
    logic             scan_found;
    logic             scan_pass;
    logic             after_found;
    logic             after_pass;

    // Cyclic search: first unmasked channel at/after eff_sel, then the first
    // unmasked channel strictly after that one; record any N-1 -> 0 crossing
    always_comb begin
        int j;
        j           = 0;
        scan_idx    = eff_sel;
        scan_found  = 1'b0;
        scan_pass   = 1'b0;
        after_idx   = eff_sel;
        after_found = 1'b0;
        after_pass  = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(eff_sel) + i;
            if (!scan_found && !ch_mask[j % N]) begin
                scan_found = 1'b1;
                scan_idx   = SEL_W'(j % N);
                scan_pass  = (j >= N);
            end
        end
        for (int i = 1; i <= N; i++) begin
            j = int'(scan_idx) + i;
            if (!after_found && !ch_mask[j % N]) begin
                after_found = 1'b1;
                after_idx   = SEL_W'(j % N);
                after_pass  = (j >= N);
            end
        end
    end
`endif

    // Decide whether this cycle samples, which channel, and the follow-on select
    always_comb begin
        take     = 1'b0;
        samp_sel = eff_sel;
        sel_nxt  = eff_sel;
        wrap_nxt = 1'b0;
        case (next_state)
            MANUAL: begin
`ifdef CH_MASK_EN
                take = !ch_mask[eff_sel];
                if (&ch_mask) sel_nxt = cur_sel;
`else
                take = 1'b1;
`endif
            end
            SCAN: begin
`ifdef CH_MASK_EN
                if (scan_found) begin
                    take     = 1'b1;
                    samp_sel = scan_idx;
                    sel_nxt  = after_idx;
                    wrap_nxt = scan_pass | after_pass;
                end else begin
                    sel_nxt  = cur_sel;
                end
`else
                take     = 1'b1;
                wrap_nxt = (eff_sel == LAST);
                sel_nxt  = (eff_sel == LAST) ? '0 : eff_sel + SEL_W'(1);
`endif
            end
            default: ;
        endcase
    end

    // Registered outputs and state; reset abandons any scan position
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            cur_sel    <= '0;
            wrap       <= 1'b0;
        end else begin
            state      <= next_state;
            if (take) dout <= chan[samp_sel];
            dout_valid <= take;
            cur_sel    <= sel_nxt;
            wrap       <= wrap_nxt;
        end
    end

endmodule
